// File: rtl/analyzer_pkg.sv
// rtl/analyzer_pkg.sv - shared types, analyzer indices and priority helper for the analyzer scheduler
package analyzer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_SETTLE,
        ST_WAIT,
        ST_NEXT,
        ST_RESULT
    } state_t;

    localparam int AN_FIB    = 0;
    localparam int AN_PRIME  = 1;
    localparam int AN_EVEN   = 2;
    localparam int AN_SQUARE = 3;
    localparam int MAX_AN    = 8;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [2:0] lowest_set(input logic [MAX_AN-1:0] mask);
        lowest_set = 3'd0;
        for (int i = MAX_AN - 1; i >= 0; i--) begin
            if (mask[i]) lowest_set = 3'(i);
        end
    endfunction

endpackage

// File: rtl/an_watchdog.sv
// rtl/an_watchdog.sv - saturating per-run watchdog with an expire flag on the last allowed cycle
module an_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT) + 1;

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/analyzer_scheduler.sv
// rtl/analyzer_scheduler.sv - runs selected number analyzers one at a time and returns flag/timeout words
module analyzer_scheduler
    import analyzer_pkg::*;
#(
    parameter int NUM_AN  = 4,
    parameter int TIMEOUT = 1024,
    parameter int SETTLE  = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [31:0]       REQ_N,
    input  logic [NUM_AN-1:0] REQ_MASK,
    output logic [31:0]       AN_N,
    output logic [NUM_AN-1:0] AN_RESET,
    input  logic [NUM_AN-1:0] AN_O,
    input  logic [NUM_AN-1:0] AN_DONE,
    output logic              RES_VALID,
    input  logic              RES_READY,
    output logic [NUM_AN-1:0] RES_FLAGS,
    output logic [NUM_AN-1:0] RES_TMO,
    output logic [31:0]       RES_N
);
    localparam int CUR_W = (NUM_AN > 1) ? $clog2(NUM_AN) : 1;
    localparam int SW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t              state, next_state;
    logic [NUM_AN-1:0]   mask;
    logic [NUM_AN-1:0]   mask_rest;
    logic [MAX_AN-1:0]   mask_wide;
    logic [2:0]          next_idx;
    logic [CUR_W-1:0]    cur;
    logic [SW-1:0]       settle_cnt;
    logic                expire;
    logic                accept;

    assign accept    = REQ_VALID && REQ_READY && (state == ST_IDLE);
    assign mask_rest = mask & ~(NUM_AN'(1) << cur);
    assign RES_VALID = (state == ST_RESULT);

    // One priority encoder serves both the first pick (from the request) and later picks.
    always_comb begin
        mask_wide = '0;
        mask_wide[NUM_AN-1:0] = (state == ST_IDLE) ? REQ_MASK : mask_rest;
        next_idx = lowest_set(mask_wide);
    end

    always_comb begin
        AN_RESET = '1;
        if ((state == ST_SETTLE) || (state == ST_WAIT)) AN_RESET[cur] = 1'b0;
    end

    an_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (CLK),
        .reset  (RESET),
        .clear  (state != ST_WAIT),
        .enable (state == ST_WAIT),
        .expire (expire)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (accept) next_state = (REQ_MASK == '0) ? ST_RESULT : ST_LAUNCH;
            ST_LAUNCH: next_state = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == SW'(SETTLE - 1)) next_state = ST_WAIT;
            ST_WAIT:   if (AN_DONE[cur] || expire) next_state = ST_NEXT;
            ST_NEXT:   next_state = (mask_rest == '0) ? ST_RESULT : ST_LAUNCH;
            ST_RESULT: if (RES_READY) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_IDLE;
            REQ_READY  <= 1'b0;
            AN_N       <= '0;
            RES_N      <= '0;
            RES_FLAGS  <= '0;
            RES_TMO    <= '0;
            mask       <= '0;
            cur        <= '0;
            settle_cnt <= '0;
        end else begin
            state     <= next_state;
            REQ_READY <= (next_state == ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        AN_N      <= REQ_N;
                        RES_N     <= REQ_N;
                        mask      <= REQ_MASK;
                        RES_FLAGS <= '0;
                        RES_TMO   <= '0;
                        cur       <= next_idx[CUR_W-1:0];
                    end
                end
                ST_LAUNCH: settle_cnt <= '0;
                ST_SETTLE: settle_cnt <= settle_cnt + 1'b1;
                ST_WAIT: begin
                    // DONE takes priority over a watchdog expiry in the same cycle.
                    if (AN_DONE[cur]) begin
                        RES_FLAGS[cur] <= AN_O[cur];
                    end else if (expire) begin
                        RES_TMO[cur]   <= 1'b1;
                        RES_FLAGS[cur] <= 1'b0;
                    end
                end
                ST_NEXT: begin
                    mask <= mask_rest;
                    cur  <= next_idx[CUR_W-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_analyzer_scheduler.sv
// tb/tb_analyzer_scheduler.sv - scoreboard bench with stub analyzers and a behavioural job model
module tb_analyzer_scheduler;
    import analyzer_pkg::*;

    localparam int NA  = 4;
    localparam int TMO = 16;
    localparam int ST  = 2;
    localparam int NEVER = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, req_valid, req_ready, res_valid, res_ready;
    logic [31:0]   req_n, an_n, res_n;
    logic [NA-1:0] req_mask, an_reset, an_o, an_done, res_flags, res_tmo;

    analyzer_scheduler #(.NUM_AN(NA), .TIMEOUT(TMO), .SETTLE(ST)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .REQ_VALID (req_valid),
        .REQ_READY (req_ready),
        .REQ_N     (req_n),
        .REQ_MASK  (req_mask),
        .AN_N      (an_n),
        .AN_RESET  (an_reset),
        .AN_O      (an_o),
        .AN_DONE   (an_done),
        .RES_VALID (res_valid),
        .RES_READY (res_ready),
        .RES_FLAGS (res_flags),
        .RES_TMO   (res_tmo),
        .RES_N     (res_n)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int seen = 0;
    int hold_until = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stub analyzers: DONE rises on the d-th WAIT cycle; optional stale DONE with inverted O
    // while the analyzer is held in reset or still settling.
    int cnt[NA];
    int d_cfg[NA];
    bit o_cfg[NA];
    bit stale_cfg[NA];

    always @(posedge clk) begin
        for (int i = 0; i < NA; i++) cnt[i] <= an_reset[i] ? 0 : cnt[i] + 1;
    end

    always_comb begin
        logic sn;
        sn = 1'b0;
        an_done = '0;
        an_o = '0;
        for (int i = 0; i < NA; i++) begin
            sn = stale_cfg[i] && (cnt[i] < ST);
            an_done[i] = (cnt[i] >= ST + d_cfg[i] - 1) || sn;
            an_o[i] = sn ? ~o_cfg[i] : o_cfg[i];
        end
    end

    typedef struct {
        logic [NA-1:0] flags;
        logic [NA-1:0] tmo;
        logic [31:0]   n;
        logic [31:0]   order;
        int            lat;
        int            acc;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t model(input logic [31:0] n, input logic [NA-1:0] m);
        exp_t e;
        e.flags = '0;
        e.tmo = '0;
        e.n = n;
        e.order = 0;
        e.lat = 1;
        e.acc = 0;
        for (int i = 0; i < NA; i++) begin
            if (m[i]) begin
                e.order = (e.order << 4) | 32'(i + 1);
                if (d_cfg[i] <= TMO) e.flags[i] = o_cfg[i];
                else e.tmo[i] = 1'b1;
                e.lat += 2 + ST + ((d_cfg[i] <= TMO) ? d_cfg[i] : TMO);
            end
        end
        return e;
    endfunction

    task automatic run_job(input logic [31:0] n, input logic [NA-1:0] m, input bit wait_res);
        exp_t e;
        int k;
        int target;
        e = model(n, m);
        @(negedge clk);
        req_n = n;
        req_mask = m;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("req_accept_wait", 32'(k < 5000), 1);
        e.acc = cyc;
        target = seen + 1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        exp_q.push_back(e);
        if (wait_res) begin
            k = 0;
            while (seen < target && k < 3000) begin
                @(negedge clk);
                k++;
            end
            check("result_wait", 32'(seen >= target), 1);
        end
    endtask

    task automatic set_an(input int i, input int d, input bit o, input bit s);
        d_cfg[i] = d;
        o_cfg[i] = o;
        stale_cfg[i] = s;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_res_valid"}, 32'(res_valid), 0);
        check({tag, "_res_flags"}, 32'(res_flags), 0);
        check({tag, "_res_tmo"}, 32'(res_tmo), 0);
        check({tag, "_res_n"}, res_n, 0);
        check({tag, "_an_n"}, an_n, 0);
        check({tag, "_an_reset"}, 32'(an_reset), 32'hF);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            res_ready = (cyc < hold_until) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: tracks the order in which analyzers are released and checks each result.
    initial begin
        exp_t cur_e;
        logic [31:0] obs;
        bit prev_high;
        bit in_res;
        int zeros;
        int idx;
        obs = 0;
        prev_high = 1'b1;
        in_res = 1'b0;
        cur_e = '{default: 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                obs = 0;
                prev_high = 1'b1;
                in_res = 1'b0;
            end else begin
                zeros = 0;
                idx = 0;
                for (int i = 0; i < NA; i++) begin
                    if (!an_reset[i]) begin
                        zeros++;
                        idx = i;
                    end
                end
                if (zeros == 0) begin
                    prev_high = 1'b1;
                end else begin
                    if (zeros > 1) obs = 32'hFFFF_FFFF;
                    else if (prev_high) obs = (obs << 4) | 32'(idx + 1);
                    prev_high = 1'b0;
                end
                if (res_valid) begin
                    if (!in_res) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_result: got flags=%0h n=%0h with nothing expected", res_flags, res_n);
                            cur_e = '{default: 0};
                        end else begin
                            cur_e = exp_q.pop_front();
                            check("latency", 32'(cyc - cur_e.acc), 32'(cur_e.lat));
                            check("res_flags", 32'(res_flags), 32'(cur_e.flags));
                            check("res_tmo", 32'(res_tmo), 32'(cur_e.tmo));
                            check("res_n", res_n, cur_e.n);
                            check("an_n", an_n, cur_e.n);
                            check("run_order", obs, cur_e.order);
                        end
                        obs = 0;
                        seen++;
                        in_res = 1'b1;
                    end else begin
                        check("hold_flags", 32'(res_flags), 32'(cur_e.flags));
                        check("hold_tmo", 32'(res_tmo), 32'(cur_e.tmo));
                        check("hold_n", res_n, cur_e.n);
                    end
                    check("req_ready_in_result", 32'(req_ready), 0);
                    if (res_ready) in_res = 1'b0;
                end
            end
        end
    end

    initial begin
        int k;
        rst = 1'b1;
        req_valid = 1'b0;
        req_n = '0;
        req_mask = '0;
        res_ready = 1'b0;
        for (int i = 0; i < NA; i++) set_an(i, NEVER, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 1);

        set_an(AN_FIB, 5, 1'b1, 1'b0);
        run_job(32'd13, 4'b0001, 1'b1);

        set_an(0, 3, 1'b1, 1'b0);
        set_an(1, 4, 1'b0, 1'b0);
        set_an(2, 1, 1'b1, 1'b0);
        set_an(3, 2, 1'b1, 1'b0);
        run_job(32'd7, 4'b1011, 1'b1);

        set_an(1, NEVER, 1'b1, 1'b0);
        run_job(32'd21, 4'b0010, 1'b1);

        set_an(0, 4, 1'b0, 1'b1);
        run_job(32'd99, 4'b0001, 1'b1);

        set_an(2, TMO, 1'b1, 1'b0);
        set_an(3, TMO + 1, 1'b1, 1'b0);
        set_an(1, 1, 1'b1, 1'b0);
        run_job(32'hDEAD_BEEF, 4'b1110, 1'b1);

        hold_until = 32'h7FFF_FFFF;
        set_an(0, 2, 1'b1, 1'b0);
        run_job(32'd5, 4'b0001, 1'b1);
        hold_until = cyc + 10;
        set_an(2, 3, 1'b1, 1'b0);
        run_job(32'd6, 4'b0100, 1'b1);

        set_an(0, 2, 1'b1, 1'b0);
        set_an(1, NEVER, 1'b1, 1'b0);
        run_job(32'h1234_5678, 4'b0011, 1'b0);
        repeat (12) @(negedge clk);
        check("pre_abort_flag", 32'(res_flags), 32'h1);
        check("pre_abort_an_n", an_n, 32'h1234_5678);
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_abort", 32'(req_ready), 1);
        run_job(32'd0, 4'b0000, 1'b1);

        for (int j = 0; j < 25; j++) begin
            for (int i = 0; i < NA; i++) begin
                set_an(i, int'($urandom_range(1, 20)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            end
            run_job($urandom, 4'($urandom_range(0, 15)), 1'b1);
        end

        hold_until = 0;
        k = 0;
        while (res_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        check("drain_queue", 32'(exp_q.size()), 0);
        check("drain_idle", 32'(req_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
